alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
// Parametrised successor of the 8-bit HAVEN ALU DUT: DATA_WIDTH-generic ALU.
// - Adds ready/valid handshake on both input and result sides.
// - Adds a one-entry result buffer with backpressure.
// - Adds a multi-cycle iterative multiplier.
// Sits between the HAVEN input driver (operand/opcode side) and the result monitor/scoreboard.
// PARAMETERS
// DATA_WIDTH  8  operand width, >=2; result width RW = 2*DATA_WIDTH
// MUL_ENABLE  1  1: MUL is iterative shift-add; 0: MUL returns 0 with 1-cycle latency
// PORTS
// CLK         in   1            clock, all logic on rising edge
// RST_N       in   1            reset, asynchronous assert, active-low
// ACT         in   1            operation request valid
// ALU_RDY     out  1            ALU can accept; transfer when ACT && ALU_RDY
// OP          in   4            opcode (table below)
// MOVI        in   2            operand-B source: 0=REG_B 1=MEM 2=IMM 3=reserved(B=0)
// REG_A       in   DATA_WIDTH   operand A
// REG_B       in   DATA_WIDTH   operand B candidate
// MEM         in   DATA_WIDTH   operand B candidate
// IMM         in   DATA_WIDTH   operand B candidate
// EX_ALU      out  RW           result, valid while EX_ALU_VLD
// EX_ALU_VLD  out  1            result valid
// EX_ALU_RDY  in   1            consumer ready; result consumed when EX_ALU_VLD && EX_ALU_RDY
// BEHAVIOUR
// Opcodes, W = DATA_WIDTH; results zero-extended to RW:
// - 0 ADD A+B, W+1 bits, carry in bit W
// - 1 SUB (A-B) mod 2^(W+1), borrow in bit W
// - 2 MUL full A*B, RW bits
// - 3 SHL A<<1, bit W = shifted-out MSB
// - 4 SHR A>>1
// - 5 ROL, 6 ROR: rotate A by 1 within W bits
// - 7 NOT A; 8 AND; 9 OR; 10 XOR; 11 NAND; 12 NOR; 13 XNOR (W bits)
// - 14 INC A+1, carry in bit W; 15 DEC (A-1) mod 2^(W+1), borrow in bit W
// FSM states: IDLE, MUL_BUSY.
// - ALU_RDY = (state==IDLE) && (!EX_ALU_VLD || EX_ALU_RDY); held 0 while RST_N low.
// - ACT with ALU_RDY=0 is ignored: no capture; driver holds request.
// Single-cycle op accepted in cycle t:
// - Result registered; EX_ALU_VLD=1 at t+1.
// - Back-to-back acceptance (1 op/cycle) when EX_ALU_RDY stays 1.
// MUL (MUL_ENABLE=1) accepted in cycle t:
// - Latch A, B; go MUL_BUSY; W iterations, one per cycle.
// - Product written to result buffer; EX_ALU_VLD=1 at t+W+1.
// - Return to IDLE in the same cycle. ALU_RDY=0 throughout MUL_BUSY.
// - Buffer is always empty on MUL completion (acceptance required buffer empty/draining).
// Result buffer:
// - EX_ALU and EX_ALU_VLD stable while EX_ALU_VLD && !EX_ALU_RDY.
// - Consume and new accept in the same cycle: buffer reloaded, VLD stays 1.
// - Consume with no new result: VLD drops next cycle; EX_ALU keeps last value.
// Reset (async, any time, including mid-MUL):
// - Outputs: EX_ALU=0, EX_ALU_VLD=0, ALU_RDY=0.
// - State -> IDLE; in-flight op discarded, no result emitted.
// - ALU_RDY=1 in first cycle after RST_N deasserts.
// TESTING (DATA_WIDTH=8)
// 1 reset: hold RST_N=0 with ACT=1 -> EX_ALU_VLD=0, EX_ALU=0x0000, ALU_RDY=0;
//   release -> ALU_RDY=1 next cycle
// 2 ADD REG_A=0xFF REG_B=0x01 MOVI=0 -> next cycle EX_ALU=0x0100, VLD=1;
//   SUB A=0x00 IMM=0x01 MOVI=2 back-to-back -> EX_ALU=0x01FF the following cycle
// 3 MUL A=0xFF MEM=0xFF MOVI=1 -> ALU_RDY=0 8 cycles, EX_ALU=0xFE01 VLD=1 9 cycles after accept;
//   MUL_ENABLE=0 -> 0x0000 after 1 cycle
// 4 backpressure: EX_ALU_RDY=0, XOR A=0xAA B=0x55 -> EX_ALU=0x00FF held 5 cycles, ALU_RDY=0;
//   raise EX_ALU_RDY with ACT AND 0xF0&0x3C -> same-cycle consume+accept, next EX_ALU=0x0030
// 5 ROL A=0x81 -> 0x0003; ROR A=0x01 -> 0x0080; SHL A=0x80 -> 0x0100; DEC A=0x00 -> 0x01FF
// 6 reset mid-MUL: pulse RST_N low 3 cycles after MUL accept -> no EX_ALU_VLD ever for it;
//   next ADD 2+3 -> 0x0005

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: DATA_WIDTH-generic ALU with a ready/valid handshake on both sides.
// Holds one result in an output buffer that can be stalled by the consumer.
// MUL is an iterative shift-add multiplier that takes DATA_WIDTH cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | can accept a request when the result buffer is free/draining
// MUL_BUSY | shift-add multiply in progress, one partial product per cycle
module alu_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      ACT,
  output logic                      ALU_RDY,
  input  logic [3:0]                OP,
  input  logic [1:0]                MOVI,
  input  logic [DATA_WIDTH-1:0]     REG_A,
  input  logic [DATA_WIDTH-1:0]     REG_B,
  input  logic [DATA_WIDTH-1:0]     MEM,
  input  logic [DATA_WIDTH-1:0]     IMM,
  output logic [2*DATA_WIDTH-1:0]   EX_ALU,
  output logic                      EX_ALU_VLD,
  input  logic                      EX_ALU_RDY
);

  localparam int W  = DATA_WIDTH;
  localparam int RW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_ROL  = 4'd5;
  localparam logic [3:0] OP_ROR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_INC  = 4'd14;
  localparam logic [3:0] OP_DEC  = 4'd15;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   res_q, res_d;
  logic            vld_q, vld_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    b_op;
  logic [W:0]      wide_res;
  logic [W-1:0]    narrow_res;
  logic            use_wide;
  logic [RW-1:0]   alu_res;
  logic [RW-1:0]   partial;
  logic            accept;
  logic            mul_start;

  // Operand B source select; the reserved encoding yields zero.
  always_comb begin
    b_op = '0;
    case (MOVI)
      2'd0:    b_op = REG_B;
      2'd1:    b_op = MEM;
      2'd2:    b_op = IMM;
      default: b_op = '0;
    endcase
  end

  // Single-cycle result: carry/borrow ops produce W+1 bits, logic ops W bits.
  always_comb begin
    wide_res   = '0;
    narrow_res = '0;
    use_wide   = 1'b0;
    case (OP)
      OP_ADD:  begin use_wide = 1'b1; wide_res = {1'b0, REG_A} + {1'b0, b_op}; end
      OP_SUB:  begin use_wide = 1'b1; wide_res = {1'b0, REG_A} - {1'b0, b_op}; end
      OP_SHL:  begin use_wide = 1'b1; wide_res = {REG_A, 1'b0}; end
      OP_INC:  begin use_wide = 1'b1; wide_res = {1'b0, REG_A} + {{W{1'b0}}, 1'b1}; end
      OP_DEC:  begin use_wide = 1'b1; wide_res = {1'b0, REG_A} - {{W{1'b0}}, 1'b1}; end
      OP_SHR:  narrow_res = REG_A >> 1;
      OP_ROL:  narrow_res = {REG_A[W-2:0], REG_A[W-1]};
      OP_ROR:  narrow_res = {REG_A[0], REG_A[W-1:1]};
      OP_NOT:  narrow_res = ~REG_A;
      OP_AND:  narrow_res = REG_A & b_op;
      OP_OR:   narrow_res = REG_A | b_op;
      OP_XOR:  narrow_res = REG_A ^ b_op;
      OP_NAND: narrow_res = ~(REG_A & b_op);
      OP_NOR:  narrow_res = ~(REG_A | b_op);
      OP_XNOR: narrow_res = ~(REG_A ^ b_op);
      default: narrow_res = '0;
    endcase
    if (use_wide) alu_res = {{(RW-W-1){1'b0}}, wide_res};
    else          alu_res = {{(RW-W){1'b0}}, narrow_res};
  end

  // Handshake: only take a request when idle and the buffer will be free.
  always_comb begin
    ALU_RDY   = RST_N && (state_q == IDLE) && (!vld_q || EX_ALU_RDY);
    accept    = ACT && ALU_RDY;
    mul_start = accept && (OP == OP_MUL) && MUL_ENABLE;
    partial   = mplier_q[0] ? mcand_q : '0;
  end

  // Next state, result buffer and multiplier datapath.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    vld_d    = vld_q && !EX_ALU_RDY;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (mul_start) begin
          state_d  = MUL_BUSY;
          mcand_d  = {{(RW-W){1'b0}}, REG_A};
          mplier_d = b_op;
          acc_d    = '0;
          cnt_d    = CW'(W);
        end else if (accept) begin
          res_d = alu_res;
          vld_d = 1'b1;
        end
      end
      MUL_BUSY: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          // Buffer is guaranteed empty here: acceptance required it free.
          res_d   = acc_q + partial;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight multiply.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      res_q    <= '0;
      vld_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      vld_q    <= vld_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign EX_ALU     = res_q;
  assign EX_ALU_VLD = vld_q;

endmodule
